cpcs_enc_rd: RTL and testbench

Running-disparity and symbol-assembly stage of the CorePCS 8B10B encoder. It sits directly downstream of cpcs_enc_flip and the cpcs_enc_d/cpcs_enc_k code generators. It takes the nominal RD- 6b/4b sub-blocks plus the four flip/enable sideband bits, applies the inversions against the live running disparity (RD), and emits registered 10-bit symbols. It also inserts K28.5 fill symbols, runs a post-reset comma-preamble state machine, and flags disparity and protocol errors.

---
 rtl/cpcs_enc_rd.sv | 240 ++++++++++++++++++++++++
 tb/tb_cpcs_enc_rd.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/cpcs_enc_rd.sv
// ---------------------------------------------------------------------------
// cpcs_enc_rd
// Running-disparity and symbol-assembly stage of the CorePCS 8B10B encoder.
// Applies the RD-dependent inversions to the RD- 6b/4b sub-blocks, inserts
// K28.5 fill symbols, sends a comma preamble after reset, and raises sticky
// disparity and protocol error flags.
//
// Ports
//   CLK, RST_N        clock, asynchronous active-low reset
//   VALID_IN          CODE_6B/CODE_4B and the sideband bits are valid
//   CODE_6B, CODE_4B  RD- column sub-blocks (abcdei, fghj; a/f are the MSBs)
//   FLIP_RD           symbol changes RD
//   EN_INV_6B/4B      sub-block is RD-dependent
//   INV_4B_RD         RD toggles between the 6b and 4b sub-blocks
//   FILL_EN           emit K28.5 when no data is offered
//   FORCE_RD_EN/VAL   override the current RD for this symbol
//   ERR_CLR           clear the sticky error flags
//   TX_DATA/VALID/FILL registered output symbol and qualifiers
//   RD_OUT            RD after the last emitted symbol
//   INIT_DONE         preamble finished, data accepted
//   DISP_ERR          sticky: emitted symbol broke disparity rules
//   PROTO_ERR         sticky: data offered during the preamble
// ---------------------------------------------------------------------------
module cpcs_enc_rd #(
    parameter int RD_INIT     = 0,
    parameter int INIT_COMMAS = 4,
    parameter int BIT_REVERSE = 0
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       VALID_IN,
    input  logic [5:0] CODE_6B,
    input  logic [3:0] CODE_4B,
    input  logic       FLIP_RD,
    input  logic       EN_INV_6B,
    input  logic       EN_INV_4B,
    input  logic       INV_4B_RD,
    input  logic       FILL_EN,
    input  logic       FORCE_RD_EN,
    input  logic       FORCE_RD_VAL,
    input  logic       ERR_CLR,
    output logic [9:0] TX_DATA,
    output logic       TX_VALID,
    output logic       TX_FILL,
    output logic       RD_OUT,
    output logic       INIT_DONE,
    output logic       DISP_ERR,
    output logic       PROTO_ERR
);

    localparam logic       RD_RST   = (RD_INIT != 0) ? 1'b1 : 1'b0;
    localparam logic       DONE_RST = (INIT_COMMAS == 0) ? 1'b1 : 1'b0;
    localparam logic [7:0] INIT_CNT = 8'(INIT_COMMAS);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // K28.5 selected by the running disparity going into the symbol
    function automatic logic [9:0] k28_5(input logic rd);
        return rd ? 10'h305 : 10'h0FA;
    endfunction

    // Number of ones in a 10b symbol
    function automatic logic [3:0] ones10(input logic [9:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 10; i++) begin
            n = n + {3'd0, v[i]};
        end
        return n;
    endfunction

    // Disparity rule check on an unmirrored symbol
    function automatic logic disp_bad(input logic [9:0] sym, input logic rc, input logic rd_new);
        logic [3:0] n;
        logic       bad;
        n = ones10(sym);
        case (n)
            4'd4:    bad = ~rc;
            4'd5:    bad = (rd_new != rc);
            4'd6:    bad = rc;
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    // a lands on bit 0 when mirrored
    function automatic logic [9:0] mirror10(input logic [9:0] v);
        logic [9:0] r;
        for (int i = 0; i < 10; i++) begin
            r[i] = v[9 - i];
        end
        return r;
    endfunction

    state_t     state_r;
    logic [7:0] cnt_r;
    logic       rd_r;
    logic [9:0] tx_data_r;
    logic       tx_valid_r;
    logic       tx_fill_r;
    logic       init_done_r;
    logic       disp_err_r;
    logic       proto_err_r;

    logic       rc_s;
    logic       rm_s;
    logic [9:0] data_sym_s;
    logic       emit_s;
    logic       fill_s;
    logic [9:0] sym_s;
    logic       rd_nxt_s;
    logic       proto_s;
    logic       disp_s;
    logic [7:0] cnt_inc_s;
    logic       last_comma_s;

    assign rc_s = FORCE_RD_EN ? FORCE_RD_VAL : rd_r;
    assign rm_s = rc_s ^ INV_4B_RD;

    // RD+ versions of the sub-blocks are the bitwise complements of the RD- ones
    assign data_sym_s = {CODE_6B ^ {6{rc_s & EN_INV_6B}},
                         CODE_4B ^ {4{rm_s & EN_INV_4B}}};

    assign cnt_inc_s    = (cnt_r == 8'hFF) ? cnt_r : cnt_r + 8'd1;
    assign last_comma_s = (cnt_inc_s == INIT_CNT);

    // Symbol selection and next running disparity
    always_comb begin
        emit_s   = 1'b0;
        fill_s   = 1'b0;
        sym_s    = k28_5(rc_s);
        rd_nxt_s = rd_r;
        proto_s  = 1'b0;
        case (state_r)
            ST_INIT: begin
                // preamble commas go out regardless of FILL_EN; data is dropped
                emit_s   = 1'b1;
                fill_s   = 1'b1;
                sym_s    = k28_5(rc_s);
                rd_nxt_s = ~rc_s;
                proto_s  = VALID_IN;
            end
            ST_RUN: begin
                if (VALID_IN) begin
                    emit_s   = 1'b1;
                    sym_s    = data_sym_s;
                    rd_nxt_s = rc_s ^ FLIP_RD;
                end else if (FILL_EN) begin
                    emit_s   = 1'b1;
                    fill_s   = 1'b1;
                    sym_s    = k28_5(rc_s);
                    rd_nxt_s = ~rc_s;
                end else begin
                    emit_s   = 1'b0;
                    rd_nxt_s = rd_r;
                end
            end
            default: begin
                emit_s   = 1'b0;
                rd_nxt_s = rd_r;
            end
        endcase
        disp_s = emit_s & disp_bad(sym_s, rc_s, rd_nxt_s);
    end

    // Preamble FSM, running disparity, output symbol and sticky error flags
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_r     <= DONE_RST ? ST_RUN : ST_INIT;
            cnt_r       <= 8'd0;
            rd_r        <= RD_RST;
            tx_data_r   <= 10'd0;
            tx_valid_r  <= 1'b0;
            tx_fill_r   <= 1'b0;
            init_done_r <= DONE_RST;
            disp_err_r  <= 1'b0;
            proto_err_r <= 1'b0;
        end else begin
            case (state_r)
                ST_INIT: begin
                    cnt_r <= cnt_inc_s;
                    if (last_comma_s) begin
                        state_r     <= ST_RUN;
                        init_done_r <= 1'b1;
                    end else begin
                        state_r     <= ST_INIT;
                        init_done_r <= 1'b0;
                    end
                end
                ST_RUN: begin
                    state_r     <= ST_RUN;
                    init_done_r <= 1'b1;
                end
                default: begin
                    state_r     <= ST_INIT;
                    init_done_r <= 1'b0;
                end
            endcase

            tx_valid_r <= emit_s;
            tx_fill_r  <= fill_s;
            if (emit_s) begin
                tx_data_r <= (BIT_REVERSE != 0) ? mirror10(sym_s) : sym_s;
                rd_r      <= rd_nxt_s;
            end else begin
                tx_data_r <= tx_data_r;
                rd_r      <= rd_r;
            end

            // a new error outranks a simultaneous clear
            if (disp_s) begin
                disp_err_r <= 1'b1;
            end else if (ERR_CLR) begin
                disp_err_r <= 1'b0;
            end else begin
                disp_err_r <= disp_err_r;
            end

            if (proto_s) begin
                proto_err_r <= 1'b1;
            end else if (ERR_CLR) begin
                proto_err_r <= 1'b0;
            end else begin
                proto_err_r <= proto_err_r;
            end
        end
    end

    assign TX_DATA   = tx_data_r;
    assign TX_VALID  = tx_valid_r;
    assign TX_FILL   = tx_fill_r;
    assign RD_OUT    = rd_r;
    assign INIT_DONE = init_done_r;
    assign DISP_ERR  = disp_err_r;
    assign PROTO_ERR = proto_err_r;

endmodule

// File: tb/tb_cpcs_enc_rd.sv
// ---------------------------------------------------------------------------
// tb_cpcs_enc_rd
// Directed bench for cpcs_enc_rd with default parameters
// (RD_INIT=0, INIT_COMMAS=4, BIT_REVERSE=0). Expected symbols are hand
// computed 8B10B code groups.
// ---------------------------------------------------------------------------
module tb_cpcs_enc_rd;

    logic       CLK;
    logic       RST_N;
    logic       VALID_IN;
    logic [5:0] CODE_6B;
    logic [3:0] CODE_4B;
    logic       FLIP_RD;
    logic       EN_INV_6B;
    logic       EN_INV_4B;
    logic       INV_4B_RD;
    logic       FILL_EN;
    logic       FORCE_RD_EN;
    logic       FORCE_RD_VAL;
    logic       ERR_CLR;
    logic [9:0] TX_DATA;
    logic       TX_VALID;
    logic       TX_FILL;
    logic       RD_OUT;
    logic       INIT_DONE;
    logic       DISP_ERR;
    logic       PROTO_ERR;

    int errors = 0;
    int checks = 0;

    cpcs_enc_rd dut (
        .CLK          (CLK),
        .RST_N        (RST_N),
        .VALID_IN     (VALID_IN),
        .CODE_6B      (CODE_6B),
        .CODE_4B      (CODE_4B),
        .FLIP_RD      (FLIP_RD),
        .EN_INV_6B    (EN_INV_6B),
        .EN_INV_4B    (EN_INV_4B),
        .INV_4B_RD    (INV_4B_RD),
        .FILL_EN      (FILL_EN),
        .FORCE_RD_EN  (FORCE_RD_EN),
        .FORCE_RD_VAL (FORCE_RD_VAL),
        .ERR_CLR      (ERR_CLR),
        .TX_DATA      (TX_DATA),
        .TX_VALID     (TX_VALID),
        .TX_FILL      (TX_FILL),
        .RD_OUT       (RD_OUT),
        .INIT_DONE    (INIT_DONE),
        .DISP_ERR     (DISP_ERR),
        .PROTO_ERR    (PROTO_ERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%03h expected=0x%03h", tag, obs, exp);
        end
    endtask

    // full output snapshot: data, valid, fill, rd, done, disp_err, proto_err
    task automatic chk_all(input string tag, input logic [9:0] d, input logic v,
                           input logic f, input logic rd, input logic dn,
                           input logic de, input logic pe);
        chk({tag, ".data"}, TX_DATA, d);
        chk({tag, ".valid"}, {9'd0, TX_VALID}, {9'd0, v});
        chk({tag, ".fill"}, {9'd0, TX_FILL}, {9'd0, f});
        chk({tag, ".rd"}, {9'd0, RD_OUT}, {9'd0, rd});
        chk({tag, ".done"}, {9'd0, INIT_DONE}, {9'd0, dn});
        chk({tag, ".disp"}, {9'd0, DISP_ERR}, {9'd0, de});
        chk({tag, ".proto"}, {9'd0, PROTO_ERR}, {9'd0, pe});
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // D.0.0 sideband: 6b unbalanced, no overall flip
    task automatic set_d00();
        VALID_IN = 1'b1; CODE_6B = 6'b100111; CODE_4B = 4'b1011;
        FLIP_RD = 1'b0; EN_INV_6B = 1'b1; EN_INV_4B = 1'b1; INV_4B_RD = 1'b1;
    endtask

    // D.3.0 sideband: 6b balanced and fixed, 4b flips RD
    task automatic set_d30();
        VALID_IN = 1'b1; CODE_6B = 6'b110001; CODE_4B = 4'b1011;
        FLIP_RD = 1'b1; EN_INV_6B = 1'b0; EN_INV_4B = 1'b1; INV_4B_RD = 1'b0;
    endtask

    task automatic set_idle();
        VALID_IN = 1'b0; CODE_6B = 6'd0; CODE_4B = 4'd0; FLIP_RD = 1'b0;
        EN_INV_6B = 1'b0; EN_INV_4B = 1'b0; INV_4B_RD = 1'b0;
    endtask

    initial begin
        RST_N = 1'b0; FILL_EN = 1'b0; FORCE_RD_EN = 1'b0; FORCE_RD_VAL = 1'b0;
        ERR_CLR = 1'b0;
        set_idle();
        #3;
        chk_all("reset", 10'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #9 RST_N = 1'b1;

        // comma preamble, RD alternates, done with the 4th comma
        tick(); chk_all("init1", 10'h0FA, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(); chk_all("init2", 10'h305, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(); chk_all("init3", 10'h0FA, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(); chk_all("init4", 10'h305, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);

        // D.0.0 at RD-
        set_d00();
        tick(); chk_all("d00_rdm", 10'h274, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

        // fill at RD- then D.0.0 at RD+
        set_idle(); FILL_EN = 1'b1;
        tick(); chk_all("fill_rdm", 10'h0FA, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        set_d00();
        tick(); chk_all("d00_rdp", 10'h18B, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);

        // back-to-back RD-flipping D.3.0
        set_d30();
        tick(); chk_all("b2b1", 10'h314, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick(); chk_all("b2b2", 10'h31B, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        tick(); chk_all("b2b3", 10'h314, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick(); chk_all("b2b4", 10'h31B, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        tick(); chk_all("b2b5", 10'h314, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

        // fill at RD-, then idle holds data and RD
        set_idle(); FILL_EN = 1'b1;
        tick(); chk_all("fill2", 10'h0FA, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        FILL_EN = 1'b0;
        tick(); chk_all("idle1", 10'h0FA, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        FORCE_RD_EN = 1'b1; FORCE_RD_VAL = 1'b0;
        tick(); chk_all("idle2", 10'h0FA, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        FORCE_RD_EN = 1'b0;

        // fill at RD+ brings RD back to 0
        FILL_EN = 1'b1;
        tick(); chk_all("fill_rdp", 10'h305, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        FILL_EN = 1'b0;

        // forced RD+ while RD_OUT=0
        set_d00(); FORCE_RD_EN = 1'b1; FORCE_RD_VAL = 1'b1;
        tick(); chk_all("force", 10'h18B, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        FORCE_RD_EN = 1'b0; FORCE_RD_VAL = 1'b0;

        // forced RD- on a fill while RD_OUT=1
        set_idle(); FILL_EN = 1'b1; FORCE_RD_EN = 1'b1;
        tick(); chk_all("force_fill", 10'h0FA, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        FILL_EN = 1'b0; FORCE_RD_EN = 1'b0;

        // bad symbol at RD+: 1001111011 has 7 ones
        set_d00(); EN_INV_6B = 1'b0; EN_INV_4B = 1'b0;
        tick(); chk_all("disp_bad", 10'h27B, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        set_idle(); ERR_CLR = 1'b1;
        tick(); chk_all("disp_clr", 10'h27B, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        set_d00(); EN_INV_6B = 1'b0; EN_INV_4B = 1'b0;
        tick(); chk_all("disp_win", 10'h27B, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        ERR_CLR = 1'b0;

        // async reset between clock edges
        set_d30();
        #2 RST_N = 1'b0;
        #1 chk_all("arst", 10'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        chk_all("arst_hold", 10'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #2 RST_N = 1'b1;

        // INIT restarts; data offered during INIT is dropped and flagged
        tick(); chk_all("re_init1", 10'h0FA, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        set_idle(); ERR_CLR = 1'b1;
        tick(); chk_all("re_init2", 10'h305, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        set_d00();
        tick(); chk_all("re_init3", 10'h0FA, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        set_idle(); ERR_CLR = 1'b0;
        tick(); chk_all("re_init4", 10'h305, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);

        // data accepted after the restarted preamble
        set_d00();
        tick(); chk_all("post_init", 10'h274, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        set_idle();
        tick(); chk_all("post_idle", 10'h274, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
